// File: rtl/mac_seq_pkg.sv
// ---------------------------------------------------------------------------
// mac_seq_pkg
// Shared definitions for the MAC dot-product sequencer: the default datapath
// widths and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package mac_seq_pkg;

  localparam int DATA_W_DEF = 8;   // operand width (unsigned)
  localparam int ACC_W_DEF  = 16;  // accumulator width, >= 2*DATA_W
  localparam int LEN_W_DEF  = 8;   // job length field width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a job command
    ST_RUN  = 2'd1,  // accepting operand pairs
    ST_DONE = 2'd2   // presenting the result
  } state_e;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// ---------------------------------------------------------------------------
// mac_dot_sequencer_if
// Bundles the three handshakes of the dot-product sequencer plus its control
// and status lines.
//   cmd_*   : job command (length) from the operand source
//   abort   : synchronous abort of the current job
//   op_*    : operand pair stream
//   res_*   : result (sum + sticky overflow) to the consumer
//   busy    : sequencer is running or holding a result
// Modports:
//   master : the environment side (drives commands/operands, consumes result)
//   slave  : the sequencer side
// ---------------------------------------------------------------------------
interface mac_dot_sequencer_if
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_ovf;
  logic              busy;

  modport master (
    output cmd_valid, cmd_len, abort, op_valid, op_a, op_b, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data, res_ovf, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, abort, op_valid, op_a, op_b, res_ready,
    output cmd_ready, op_ready, res_valid, res_data, res_ovf, busy
  );

endinterface

// File: rtl/mac_acc_datapath.sv
// ---------------------------------------------------------------------------
// mac_acc_datapath
// Purely combinational MAC step: unsigned multiply of the two operands, the
// product zero-extended to ACC_W and added to the current accumulator with
// carry-in tied to zero. The sum wraps mod 2**ACC_W; the carry-out is
// reported separately so the sequencer can track overflow.
// Ports:
//   acc_i   in  ACC_W   current accumulator value
//   a_i     in  DATA_W  operand A
//   b_i     in  DATA_W  operand B
//   sum_o   out ACC_W   acc_i + a_i*b_i, mod 2**ACC_W
//   carry_o out 1       carry out of bit ACC_W-1
// ---------------------------------------------------------------------------
module mac_acc_datapath
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF   // must be >= 2*DATA_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [2*DATA_W-1:0] product;
  logic [ACC_W:0]      sum_ext;

  // Operands are widened first so the multiply is evaluated at full product
  // width rather than truncated to DATA_W.
  assign product = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

  // One extra bit on both addends captures the carry-out.
  assign sum_ext = (ACC_W+1)'(acc_i) + (ACC_W+1)'(product);

  assign sum_o   = sum_ext[ACC_W-1:0];
  assign carry_o = sum_ext[ACC_W];

endmodule

// File: rtl/mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// mac_dot_sequencer
// Runs dot-product jobs through the MAC datapath. A job command carries the
// number of operand pairs; the pairs are then streamed one per cycle at most,
// accumulated, and the sum plus a sticky overflow flag is returned on the
// result handshake. A length of zero produces an immediate zero result.
// All handshake outputs are decoded from registered state only (Moore).
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of mac_dot_sequencer_if (cmd/op/res handshakes,
//          abort, busy)
// ---------------------------------------------------------------------------
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_dot_sequencer_if.slave   bus
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic               ovf_q,   ovf_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q,   len_d;

  logic [ACC_W-1:0]   dp_sum;
  logic               dp_carry;
  logic               last_beat;

  mac_acc_datapath #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_datapath (
    .acc_i   (acc_q),
    .a_i     (bus.op_a),
    .b_i     (bus.op_b),
    .sum_o   (dp_sum),
    .carry_o (dp_carry)
  );

  // RUN is only entered with len_q >= 1, so len_q-1 never underflows here.
  // count_q stops at len_q-1 on the terminal beat, so even the maximum
  // length never needs the counter to wrap.
  assign last_beat = (count_q == len_q - LEN_W'(1));

  // Next-state and datapath control.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    len_d   = len_q;

    unique case (state_q)
      ST_IDLE: begin
        // An abort seen in IDLE suppresses command acceptance that cycle.
        if (bus.cmd_valid && !bus.abort) begin
          len_d   = bus.cmd_len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = (bus.cmd_len == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        // Abort takes priority over a coincident operand beat.
        if (bus.abort) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = ST_IDLE;
        end else if (bus.op_valid) begin
          acc_d   = dp_sum;
          ovf_d   = ovf_q | dp_carry;
          count_d = count_q + LEN_W'(1);
          if (last_beat) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (bus.abort) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = ST_IDLE;
        end else if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  // acc/count/len are ordinary registers, not a memory, so they take the
  // async reset along with the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // Moore outputs. The accumulator only changes on accepted beats or a new
  // command, so res_data/res_ovf hold stable for as long as DONE is stalled.
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.op_ready  = (state_q == ST_RUN);
  assign bus.res_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.res_data  = acc_q;
  assign bus.res_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mac_dot_sequencer
// Self-checking bench for mac_dot_sequencer: a table of directed jobs with
// hand-computed results, hand-written abort/reset sequences, and random jobs
// whose expected result comes from a plain integer sum of products.
// ---------------------------------------------------------------------------
module tb_mac_dot_sequencer;
  import mac_seq_pkg::*;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int LEN_W  = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mac_dot_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  mac_dot_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];

  typedef struct {
    string            name;
    int               len;
    logic [7:0]       a [4];
    logic [7:0]       b [4];
    int               gmin;
    int               gmax;
    int               stall;
    logic [ACC_W-1:0] exp_data;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one job using operands queued in qa/qb and checks the result.
  task automatic run_job(input string tag, input int len, input int gmin, input int gmax,
                         input int stall, input logic [ACC_W-1:0] exp_data, input logic exp_ovf);
    int waited;
    int gaps;
    logic [ACC_W-1:0] held;
    waited = 0;
    while (!bus.cmd_ready && waited < 20) begin
      step();
      waited++;
    end
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LEN_W'(len);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      gaps = $urandom_range(gmax, gmin);
      for (int g = 0; g < gaps; g++) step();
      check({tag, "_op_ready"}, 32'(bus.op_ready), 32'd1);
      bus.op_valid = 1'b1;
      bus.op_a     = qa.pop_front();
      bus.op_b     = qb.pop_front();
      step();
      bus.op_valid = 1'b0;
    end
    if (len == 0) check({tag, "_op_ready_len0"}, 32'(bus.op_ready), 32'd0);
    // Result must be valid exactly one cycle after the last beat/command.
    check({tag, "_res_valid_latency"}, 32'(bus.res_valid), 32'd1);
    held = bus.res_data;
    for (int s = 0; s < stall; s++) begin
      bus.res_ready = 1'b0;
      step();
      check({tag, "_stall_valid"}, 32'(bus.res_valid), 32'd1);
      check({tag, "_stall_stable"}, 32'(bus.res_data), 32'(held));
    end
    check({tag, "_res_data"}, 32'(bus.res_data), 32'(exp_data));
    check({tag, "_res_ovf"}, 32'(bus.res_ovf), 32'(exp_ovf));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
  endtask

  // Reference model: exact integer sum of products, then reduced mod 2**ACC_W.
  // Products are non-negative, so the true sum reaches 2**ACC_W exactly when
  // some accumulate step carried out.
  task automatic random_job(input string tag, input int len, input int gmax, input int stall);
    longint total;
    logic [7:0] a, b;
    total = 0;
    for (int i = 0; i < len; i++) begin
      a = 8'($urandom_range(255, 0));
      b = 8'($urandom_range(255, 0));
      qa.push_back(a);
      qb.push_back(b);
      total += longint'(a) * longint'(b);
    end
    run_job(tag, len, 0, gmax, stall, ACC_W'(total % 65536), (total >= 65536));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"len3_basic",  3, '{8'd2, 8'd4, 8'd255, 8'd0},   '{8'd3, 8'd5, 8'd255, 8'd0},
                0, 0, 0, 16'd65051, 1'b0};
    vecs[1] = '{"len2_ovf",    2, '{8'd255, 8'd255, 8'd0, 8'd0}, '{8'd255, 8'd255, 8'd0, 8'd0},
                0, 0, 0, 16'd64514, 1'b1};
    vecs[2] = '{"len0",        0, '{8'd0, 8'd0, 8'd0, 8'd0},     '{8'd0, 8'd0, 8'd0, 8'd0},
                0, 0, 2, 16'd0, 1'b0};
    vecs[3] = '{"len4_gaps",   4, '{8'd10, 8'd30, 8'd50, 8'd70}, '{8'd20, 8'd40, 8'd60, 8'd80},
                1, 3, 5, 16'd10000, 1'b0};
    vecs[4] = '{"len4_ovf_mid", 4, '{8'd200, 8'd200, 8'd1, 8'd0}, '{8'd200, 8'd200, 8'd1, 8'd9},
                0, 1, 1, 16'd14465, 1'b1};

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;
    step();
    step();
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_op_ready",  32'(bus.op_ready),  32'd0);
    check("reset_res_valid", 32'(bus.res_valid), 32'd0);
    check("reset_busy",      32'(bus.busy),      32'd0);
    check("reset_res_data",  32'(bus.res_data),  32'd0);
    check("reset_res_ovf",   32'(bus.res_ovf),   32'd0);
    rst_n = 1'b1;
    step();

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].len; i++) begin
        qa.push_back(vecs[v].a[i]);
        qb.push_back(vecs[v].b[i]);
      end
      run_job(vecs[v].name, vecs[v].len, vecs[v].gmin, vecs[v].gmax, vecs[v].stall,
              vecs[v].exp_data, vecs[v].exp_ovf);
    end

    // Abort coincident with beat 2 of a len=4 job: beat dropped, no result.
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd4;
    step();
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_a      = 8'd1;
    bus.op_b      = 8'd1;
    step();
    bus.op_a      = 8'd9;
    bus.op_b      = 8'd9;
    bus.abort     = 1'b1;
    step();
    bus.abort     = 1'b0;
    bus.op_valid  = 1'b0;
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_busy",      32'(bus.busy),      32'd0);
    check("abort_res_valid", 32'(bus.res_valid), 32'd0);
    step();
    check("abort_no_result", 32'(bus.res_valid), 32'd0);
    qa.push_back(8'd3);
    qb.push_back(8'd7);
    run_job("after_abort", 1, 0, 0, 0, 16'd21, 1'b0);

    // Abort in IDLE blocks command acceptance for that cycle.
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd2;
    bus.abort     = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    check("idle_abort_busy",      32'(bus.busy),      32'd0);
    check("idle_abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Command presented while RUN must be ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd2;
    step();
    bus.cmd_len   = 8'd0;
    bus.op_valid  = 1'b1;
    bus.op_a      = 8'd6;
    bus.op_b      = 8'd6;
    step();
    bus.cmd_valid = 1'b0;
    bus.op_a      = 8'd2;
    bus.op_b      = 8'd5;
    step();
    bus.op_valid  = 1'b0;
    check("run_cmd_ignored_valid", 32'(bus.res_valid), 32'd1);
    check("run_cmd_ignored_data",  32'(bus.res_data),  32'd46);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;

    // Async reset mid-RUN: outputs return to reset values without a clock.
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 8'd4;
    step();
    bus.cmd_valid = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_a      = 8'd5;
    bus.op_b      = 8'd5;
    step();
    bus.op_valid  = 1'b0;
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("midrst_op_ready",  32'(bus.op_ready),  32'd0);
    check("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    check("midrst_busy",      32'(bus.busy),      32'd0);
    check("midrst_res_data",  32'(bus.res_data),  32'd0);
    check("midrst_res_ovf",   32'(bus.res_ovf),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Maximum length: the counter must reach the terminal beat without wrapping.
    random_job("len255", 255, 0, 0);

    // Randomised jobs.
    for (int j = 0; j < 20; j++) begin
      random_job("rand", $urandom_range(8, 0), 2, $urandom_range(2, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
